// File: rtl/rv32i_trace_buffer_if.sv
// ============================================================================
// Module      : rv32i_trace_buffer_if
// Description : Sample, trigger and readout signals for rv32i_trace_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rv32i_trace_buffer_if #(
    parameter int ADDR_W = 6
);
    logic [31:0]     pc_in;
    logic [31:0]     op_in;
    logic [31:0]     alu_in;
    logic            capture_en;
    logic            arm;
    logic            trig_en;
    logic [31:0]     trig_pc;
    logic            rd_ready;
    logic            rd_valid;
    logic [31:0]     rd_pc;
    logic [31:0]     rd_op;
    logic [31:0]     rd_alu;
    logic [ADDR_W:0] count;
    logic            overflow;
    logic            triggered;
    logic [1:0]      state;

    modport master (
        output pc_in, op_in, alu_in, capture_en, arm, trig_en, trig_pc, rd_ready,
        input  rd_valid, rd_pc, rd_op, rd_alu, count, overflow, triggered, state
    );

    modport slave (
        input  pc_in, op_in, alu_in, capture_en, arm, trig_en, trig_pc, rd_ready,
        output rd_valid, rd_pc, rd_op, rd_alu, count, overflow, triggered, state
    );
endinterface

`default_nettype wire

// File: rtl/rv32i_trace_buffer.sv
// ============================================================================
// Module      : rv32i_trace_buffer
// Description : Circular trace buffer with PC trigger, post-trigger freeze and
//               oldest-first drain. Define TRACE_DEDUP_EN to drop repeated PCs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv32i_trace_buffer #(
    parameter int DEPTH     = 64,
    parameter int ADDR_W    = 6,
    parameter int POST_TRIG = 16
) (
    input  wire logic               clock,
    input  wire logic               reset,
    rv32i_trace_buffer_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        POST   = 2'd2,
        FROZEN = 2'd3
    } state_t;

    localparam logic [ADDR_W:0]   c_full = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] c_post = ADDR_W'(POST_TRIG);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W-1:0] post_q, post_d;
    logic              overflow_q, overflow_d;
    logic              triggered_q, triggered_d;
    logic [95:0]       mem_q [DEPTH];

    logic        w_capture;
    logic        w_new_pc;
    logic        w_write;
    logic        w_pop;
    logic        w_hit;
    logic        w_valid;
    logic [95:0] w_head;

`ifdef TRACE_DEDUP_EN
    logic [31:0] last_pc_q, last_pc_d;
    logic        have_last_q, have_last_d;

    // First write after arm always lands; afterwards a repeated PC is a stall.
    assign w_new_pc = !have_last_q || (bus.pc_in != last_pc_q);

    always_comb begin
        last_pc_d   = last_pc_q;
        have_last_d = have_last_q;
        if (bus.arm) begin
            have_last_d = 1'b0;
        end else if (w_write) begin
            last_pc_d   = bus.pc_in;
            have_last_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_pc_q   <= '0;
            have_last_q <= 1'b0;
        end else begin
            last_pc_q   <= last_pc_d;
            have_last_q <= have_last_d;
        end
    end
`else
    assign w_new_pc = 1'b1;
`endif

    assign w_capture = bus.capture_en && !bus.arm && (state_q == ARMED || state_q == POST);
    assign w_write   = w_capture && w_new_pc;
    assign w_hit     = bus.trig_en && (bus.pc_in == bus.trig_pc);
    assign w_valid   = (state_q == FROZEN) && (count_q != '0);
    assign w_pop     = w_valid && bus.rd_ready && !bus.arm;
    assign w_head    = mem_q[rd_ptr_q];

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        post_d      = post_q;
        overflow_d  = overflow_q;
        triggered_d = triggered_q;

        if (bus.arm) begin
            state_d     = ARMED;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            post_d      = '0;
            overflow_d  = 1'b0;
            triggered_d = 1'b0;
        end else begin
            if (w_write) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                // A full buffer drops its oldest entry to make room.
                if (count_q == c_full) begin
                    rd_ptr_d   = rd_ptr_q + 1'b1;
                    overflow_d = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end

                if (state_q == ARMED && w_hit) begin
                    triggered_d = 1'b1;
                    if (POST_TRIG == 0) begin
                        state_d = FROZEN;
                    end else begin
                        post_d  = c_post;
                        state_d = POST;
                    end
                end else if (state_q == POST) begin
                    post_d = post_q - 1'b1;
                    if (post_q == ADDR_W'(1)) begin
                        state_d = FROZEN;
                    end
                end
            end

            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                count_d  = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            post_q      <= '0;
            overflow_q  <= 1'b0;
            triggered_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            post_q      <= post_d;
            overflow_q  <= overflow_d;
            triggered_q <= triggered_d;
        end
    end

    // Storage carries no reset; entries are only visible once written.
    always_ff @(posedge clock) begin
        if (w_write) begin
            mem_q[wr_ptr_q] <= {bus.pc_in, bus.op_in, bus.alu_in};
        end
    end

    assign bus.rd_valid  = w_valid;
    assign bus.rd_pc     = w_valid ? w_head[95:64] : 32'd0;
    assign bus.rd_op     = w_valid ? w_head[63:32] : 32'd0;
    assign bus.rd_alu    = w_valid ? w_head[31:0]  : 32'd0;
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;
    assign bus.triggered = triggered_q;
    assign bus.state     = state_q;

endmodule

`default_nettype wire
